// File: rtl/seq_mult32.sv
// Iterative unsigned 32x32->64 shift-and-add multiplier.
// One partial-product add per clock through a single 32-bit ripple-carry
// adder; operands and product move over valid/ready handshakes.

// 32-bit ripple-carry adder: chain of full-adder cells.
module fa32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] carry;

    assign carry[0] = cin;

    // Per-bit full adder; carry ripples from bit 0 upward.
    genvar i;
    generate
        for (i = 0; i < 32; i++) begin : g_bit
            assign sum[i]     = x[i] ^ y[i] ^ carry[i];
            assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign cout = carry[32];
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | 32 shift/add iterations, one per clock
// DONE  | product presented, held until consumer takes it
module seq_mult32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0] p;
    logic [4:0]         cnt;
    logic [WIDTH-1:0]   sum;
    logic               carry;

    // Upper half of the accumulator plus multiplicand; carry lands in p[63]
    // on the following shift, so no overflow is possible.
    fa32 u_fa (
        .x    (p[2*WIDTH-1:WIDTH]),
        .y    (a_reg),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // Control FSM and datapath registers; all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_reg     <= '0;
            p         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        p        <= {{WIDTH{1'b0}}, b};
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (p[0]) begin
                        p <= {carry, sum, p[WIDTH-1:1]};
                    end else begin
                        p <= {1'b0, p[2*WIDTH-1:1]};
                    end
                    cnt <= cnt + 5'd1;
                    // Fixed 32 iterations; no early exit for small operands.
                    if (cnt == 5'd31) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign product = p;
endmodule
